// File: rtl/sprite_spi_streamer.sv
// sprite_spi_streamer
// Walks one 13x13 RGB565 sprite in raster order and streams it, upscaled
// SCALE x SCALE, to an SPI LCD: RAMWR (0x2C) command byte with dc=0, then
// every output pixel as a 16-bit word, MSB first, with dc=1. SPI mode 0.
//
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   start              1-cycle pulse, accepted only in IDLE
//   sprite_sel         sprite number, latched on an accepted start
//   mem_adress         sprite select to memory, frozen for the frame
//   mem_pixel_idx      pixel index to memory (row_base + sx), 0..168
//   mem_pixel          RGB565 from memory, combinational on the address
//   busy               high from accepted start until the done pulse
//   done               1-cycle pulse once cs_n has been released
//   lcd_cs_n/dc/sclk/mosi  SPI LCD interface
//   dbg_state          current FSM state (IDLE=0 CMD=1 LOAD=2 SHIFT=3 FIN=4)
//
// Handshake: start is a request sampled on clk only while busy=0 and the
// FSM is in IDLE; any other start pulse is dropped without side effects.
module sprite_spi_streamer #(
  parameter int SCALE   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  sprite_sel,
  output logic [2:0]  mem_adress,
  output logic [7:0]  mem_pixel_idx,
  input  logic [15:0] mem_pixel,
  output logic        busy,
  output logic        done,
  output logic        lcd_cs_n,
  output logic        lcd_dc,
  output logic        lcd_sclk,
  output logic        lcd_mosi,
  output logic [2:0]  dbg_state
);

  localparam int RW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(SCALE - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     sr_q, sr_d;
  logic [3:0]      bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            dc_q, dc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      adr_q, adr_d;
  logic [RW-1:0]   rep_x_q, rep_x_d;
  logic [RW-1:0]   rep_y_q, rep_y_d;
  logic [3:0]      sx_q, sx_d;
  logic [3:0]      sy_q, sy_d;
  logic [7:0]      row_base_q, row_base_d;

  logic            half_tick;
  logic            last_pix;
  logic [3:0]      last_bit;

  assign half_tick = (div_q == DIV_MAX);
  assign last_pix  = (sy_q == 4'd12) && (sx_q == 4'd12) &&
                     (rep_x_q == REP_MAX) && (rep_y_q == REP_MAX);
  assign last_bit  = (state_q == S_CMD) ? 4'd7 : 4'd15;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_d      = bit_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    dc_d       = dc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    adr_d      = adr_q;
    rep_x_d    = rep_x_q;
    rep_y_d    = rep_y_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    row_base_d = row_base_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          adr_d      = sprite_sel;
          rep_x_d    = '0;
          rep_y_d    = '0;
          sx_d       = '0;
          sy_d       = '0;
          row_base_d = '0;
          busy_d     = 1'b1;
          cs_n_d     = 1'b0;
          dc_d       = 1'b0;
          // Command byte sits in the top byte so mosi is always sr_q[15].
          sr_d       = {8'h2C, 8'h00};
          bit_d      = '0;
          div_d      = '0;
          sclk_d     = 1'b0;
          state_d    = S_CMD;
        end
      end

      S_CMD, S_SHIFT: begin
        if (half_tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Data moves only on the falling edge, so mosi is stable for the
          // whole low half-period before the next rising edge.
          if (sclk_q) begin
            if (bit_q == last_bit) begin
              if (state_q == S_CMD) begin
                dc_d    = 1'b1;
                state_d = S_LOAD;
              end else if (last_pix) begin
                rep_x_d    = '0;
                rep_y_d    = '0;
                sx_d       = '0;
                sy_d       = '0;
                row_base_d = '0;
                sr_d       = '0;
                cs_n_d     = 1'b1;
                dc_d       = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = S_FIN;
              end else begin
                // Nested wrap: rep_x -> sx -> rep_y -> sy/row_base.
                state_d = S_LOAD;
                if (rep_x_q == REP_MAX) begin
                  rep_x_d = '0;
                  if (sx_q == 4'd12) begin
                    sx_d = '0;
                    if (rep_y_q == REP_MAX) begin
                      rep_y_d    = '0;
                      sy_d       = sy_q + 4'd1;
                      row_base_d = row_base_q + 8'd13;
                    end else begin
                      rep_y_d = rep_y_q + RW'(1);
                    end
                  end else begin
                    sx_d = sx_q + 4'd1;
                  end
                end else begin
                  rep_x_d = rep_x_q + RW'(1);
                end
              end
            end else begin
              sr_d  = {sr_q[14:0], 1'b0};
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_LOAD: begin
        sr_d    = mem_pixel;
        bit_d   = '0;
        div_d   = '0;
        state_d = S_SHIFT;
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dc_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      adr_q      <= '0;
      rep_x_q    <= '0;
      rep_y_q    <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      dc_q       <= dc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      adr_q      <= adr_d;
      rep_x_q    <= rep_x_d;
      rep_y_q    <= rep_y_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      row_base_q <= row_base_d;
    end
  end

  assign mem_adress    = adr_q;
  assign mem_pixel_idx = row_base_q + {4'b0000, sx_q};
  assign busy          = busy_q;
  assign done          = done_q;
  assign lcd_cs_n      = cs_n_q;
  assign lcd_dc        = dc_q;
  assign lcd_sclk      = sclk_q;
  assign lcd_mosi      = sr_q[15];
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sprite_spi_streamer.sv
module tb_sprite_spi_streamer;

  // Instance A: SCALE=1, CLK_DIV=2 (full frames). Instance B: SCALE=4,
  // CLK_DIV=1 (partial frame, aborted by reset).
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, busy_a, done_a, cs_a, dc_a, sclk_a, mosi_a;
  logic [2:0]  sel_a, adr_a, st_a;
  logic [7:0]  idx_a;
  logic [15:0] pix_a;
  logic        rst_b, start_b, busy_b, done_b, cs_b, dc_b, sclk_b, mosi_b;
  logic [2:0]  sel_b, adr_b, st_b;
  logic [7:0]  idx_b;
  logic [15:0] pix_b;

  // Memory model: pixel[i] = i * 0x0101.
  assign pix_a = {idx_a, idx_a};
  assign pix_b = {idx_b, idx_b};

  sprite_spi_streamer #(.SCALE(1), .CLK_DIV(2)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .sprite_sel(sel_a),
    .mem_adress(adr_a), .mem_pixel_idx(idx_a), .mem_pixel(pix_a),
    .busy(busy_a), .done(done_a), .lcd_cs_n(cs_a), .lcd_dc(dc_a),
    .lcd_sclk(sclk_a), .lcd_mosi(mosi_a), .dbg_state(st_a)
  );

  sprite_spi_streamer #(.SCALE(4), .CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .sprite_sel(sel_b),
    .mem_adress(adr_b), .mem_pixel_idx(idx_b), .mem_pixel(pix_b),
    .busy(busy_b), .done(done_b), .lcd_cs_n(cs_b), .lcd_dc(dc_b),
    .lcd_sclk(sclk_b), .lcd_mosi(mosi_b), .dbg_state(st_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / SPI monitor ----------------
  logic [16:0] exp_q[$];   // {dc, data}
  bit          mon_en = 1'b0;
  bit          mon_b = 1'b0;
  logic [2:0]  exp_adr = '0;
  logic        prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic [15:0] shreg = '0;
  int          bits_n = 0, rx_words = 0, hi_len = 0, cyc = 0, last_rise = 0;
  bit          rise_valid = 1'b0;
  int          stab_err = 0, hi_err = 0, per_err = 0, cs_err = 0, adr_err = 0, idx_err = 0;

  logic        m_sclk, m_mosi, m_dc, m_cs, m_busy;
  logic [2:0]  m_adr;
  logic [7:0]  m_idx;
  int          m_div;
  assign m_sclk = mon_b ? sclk_b : sclk_a;
  assign m_mosi = mon_b ? mosi_b : mosi_a;
  assign m_dc   = mon_b ? dc_b   : dc_a;
  assign m_cs   = mon_b ? cs_b   : cs_a;
  assign m_busy = mon_b ? busy_b : busy_a;
  assign m_adr  = mon_b ? adr_b  : adr_a;
  assign m_idx  = mon_b ? idx_b  : idx_a;
  assign m_div  = mon_b ? 1 : 2;

  always @(negedge clk) begin
    logic [16:0] got, e;
    cyc++;
    if (mon_en) begin
      if (m_busy && m_adr !== exp_adr) adr_err++;
      if (m_idx > 8'd168) idx_err++;
      if (m_sclk) begin
        if (m_mosi !== prev_mosi) stab_err++;
        hi_len++;
      end
      if (m_sclk && !prev_sclk) begin
        if (m_cs !== 1'b0) cs_err++;
        if (rise_valid && (cyc - last_rise != 2 * m_div) && (cyc - last_rise != 2 * m_div + 1))
          per_err++;
        rise_valid = 1'b1;
        last_rise  = cyc;
        shreg  = {shreg[14:0], m_mosi};
        bits_n++;
        if (bits_n == (m_dc ? 16 : 8)) begin
          got = m_dc ? {1'b1, shreg} : {1'b0, 8'h00, shreg[7:0]};
          if (exp_q.size() == 0) begin
            check("spi_word_unexpected", {15'd0, got}, 32'h1FFFF);
          end else begin
            e = exp_q.pop_front();
            check("spi_word", {15'd0, got}, {15'd0, e});
          end
          bits_n = 0;
          rx_words++;
        end
      end
      if (!m_sclk && prev_sclk) begin
        if (hi_len != m_div) hi_err++;
        hi_len = 0;
      end
    end
    prev_sclk = m_sclk;
    prev_mosi = m_mosi;
  end

  task automatic mon_reset(input bit use_b, input logic [2:0] adr);
    mon_b = use_b;
    exp_adr = adr;
    exp_q.delete();
    bits_n = 0; rx_words = 0; hi_len = 0; rise_valid = 1'b0; shreg = '0;
    stab_err = 0; hi_err = 0; per_err = 0; cs_err = 0; adr_err = 0; idx_err = 0;
  endtask

  task automatic check_monitor_flags(input string tag);
    check({tag, "_mosi_stable"}, stab_err, 0);
    check({tag, "_sclk_high_time"}, hi_err, 0);
    check({tag, "_sclk_period"}, per_err, 0);
    check({tag, "_cs_low_in_frame"}, cs_err, 0);
    check({tag, "_adr_frozen"}, adr_err, 0);
    check({tag, "_idx_range"}, idx_err, 0);
  endtask

  // ---------------- frame table for instance A ----------------
  typedef struct {
    logic [2:0] sel;
    logic [2:0] late_sel;
    int         late_delay;
    int         exp_words;   // command byte + pixel words
  } frame_vec_t;
  frame_vec_t vecs[3];

  task automatic run_frame_a(input frame_vec_t v);
    int n;
    mon_reset(1'b0, v.sel);
    exp_q.push_back({1'b0, 16'h002C});
    for (int i = 0; i < 169; i++) begin
      logic [7:0] b8;
      b8 = i[7:0];
      exp_q.push_back({1'b1, b8, b8});
    end
    mon_en = 1'b1;
    @(negedge clk);
    sel_a = v.sel; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a_busy_after_start", busy_a, 1);
    check("a_cs_after_start", cs_a, 0);
    check("a_dc_cmd", dc_a, 0);
    check("a_adr_latched", adr_a, v.sel);
    sel_a = v.late_sel;
    repeat (v.late_delay) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("a_done_seen", done_a, 1);
    check("a_busy_at_done", busy_a, 0);
    check("a_cs_at_done", cs_a, 1);
    check("a_dc_at_done", dc_a, 0);
    check("a_sclk_at_done", sclk_a, 0);
    // start coincident with FIN must be dropped
    start_a = 1'b1; sel_a = 3'd6;
    @(negedge clk);
    start_a = 1'b0;
    check("a_done_one_cycle", done_a, 0);
    check("a_fin_start_ignored", busy_a, 0);
    check("a_idle_after_fin", st_a, 0);
    check("a_word_count", rx_words, v.exp_words);
    check("a_queue_empty", exp_q.size(), 0);
    check_monitor_flags("a");
    mon_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, done_cnt;
    vecs[0] = '{sel: 3'd2, late_sel: 3'd5, late_delay: 500,  exp_words: 170};
    vecs[1] = '{sel: 3'd6, late_sel: 3'd1, late_delay: 3000, exp_words: 170};
    vecs[2] = '{sel: 3'd0, late_sel: 3'd3, late_delay: 40,   exp_words: 170};

    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0; sel_a = '0; sel_b = '0;
    #2 rst_a = 1'b0; rst_b = 1'b0;
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_cs", cs_a, 1);
    check("rst_dc", dc_a, 0);
    check("rst_sclk", sclk_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_adr", adr_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_state", st_a, 0);
    check("rst_b_cs", cs_b, 1);
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 3; k++) run_frame_a(vecs[k]);

    // Instance B: SCALE=4 addressing, then mid-SHIFT abort.
    mon_reset(1'b1, 3'd3);
    exp_q.push_back({1'b0, 16'h002C});
    for (int w = 0; w < 220; w++) begin
      int y, x, id;
      logic [7:0] b8;
      y = w / 52;
      x = w % 52;
      id = (y / 4) * 13 + x / 4;
      b8 = id[7:0];
      exp_q.push_back({1'b1, b8, b8});
    end
    mon_en = 1'b1;
    @(negedge clk);
    sel_b = 3'd3; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    sel_b = 3'd5;
    n = 0;
    while (rx_words < 221 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("b_words_reached", rx_words, 221);
    check("b_queue_empty", exp_q.size(), 0);
    check_monitor_flags("b");
    repeat (3) @(negedge clk);
    check("b_in_shift", st_b, 3);
    check("b_busy_mid", busy_b, 1);
    mon_en = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    check("b_abort_cs", cs_b, 1);
    check("b_abort_sclk", sclk_b, 0);
    check("b_abort_busy", busy_b, 0);
    check("b_abort_mosi", mosi_b, 0);
    check("b_abort_idx", idx_b, 0);
    check("b_abort_adr", adr_b, 0);
    check("b_abort_state", st_b, 0);
    done_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_b) done_cnt++;
    end
    rst_b = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done_b) done_cnt++;
    end
    check("b_no_done_after_abort", done_cnt, 0);
    check("b_stays_idle", st_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
